rename_map: RTL

//  N-wide register rename stage directly downstream of the physical-register freelist.
//  - Requests registers (alloc_req) and consumes the one-hot grants (granted_regs).
//  - Maintains the speculative map table, the retirement map table and per-PR ready bits.
//  - Returns freed PRs to the freelist via free_mask.

---
 rtl/rename_map.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rename_map.sv
`default_nettype none
// ============================================================================
// Module   : rename_map
// Purpose  : N-wide register rename stage sitting directly behind the
//            physical-register freelist. It requests destination PRs, takes
//            the one-hot grants, renames sources with intra-group bypass, and
//            keeps the speculative map, the retirement map and per-PR ready
//            bits. PRs released by retirement, and grants that were not
//            consumed, go back to the freelist through free_mask.
// Ports    : clock, reset (sync, active-low)
//            disp_valid/disp_dest/disp_src1/disp_src2 : dispatch group
//            granted_regs                             : one-hot grants per lane
//            cdb_valid/cdb_tag                        : completion broadcast
//            ret_valid/ret_dest/ret_new_tag/ret_old_tag : retire group
//            recover                                  : mispredict flush
//            alloc_req, rename_ok, src*_tag, src*_ready,
//            new_tag, old_tag                         : combinational rename
//            free_mask                                : registered PR release
// Revision : 1.0 - initial release
// ============================================================================
module rename_map #(
  parameter int N           = 3,
  parameter int ARCH_REG_SZ = 32,
  parameter int PR_COUNT    = 64,
  parameter int AR_W        = $clog2(ARCH_REG_SZ),
  parameter int PR_W        = $clog2(PR_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N-1:0]          disp_valid,
  input  logic [N*AR_W-1:0]     disp_dest,
  input  logic [N*AR_W-1:0]     disp_src1,
  input  logic [N*AR_W-1:0]     disp_src2,
  input  logic [N*PR_COUNT-1:0] granted_regs,
  input  logic [N-1:0]          cdb_valid,
  input  logic [N*PR_W-1:0]     cdb_tag,
  input  logic [N-1:0]          ret_valid,
  input  logic [N*AR_W-1:0]     ret_dest,
  input  logic [N*PR_W-1:0]     ret_new_tag,
  input  logic [N*PR_W-1:0]     ret_old_tag,
  input  logic                  recover,
  output logic [N-1:0]          alloc_req,
  output logic [N-1:0]          rename_ok,
  output logic [N*PR_W-1:0]     src1_tag,
  output logic [N*PR_W-1:0]     src2_tag,
  output logic [N-1:0]          src1_ready,
  output logic [N-1:0]          src2_ready,
  output logic [N*PR_W-1:0]     new_tag,
  output logic [N*PR_W-1:0]     old_tag,
  output logic [PR_COUNT-1:0]   free_mask
);

  // --------------------------------------------------------------------------
  // Per-lane views of the flattened ports
  // --------------------------------------------------------------------------
  logic [AR_W-1:0]     dest_a  [N];
  logic [AR_W-1:0]     src1_a  [N];
  logic [AR_W-1:0]     src2_a  [N];
  logic [PR_COUNT-1:0] grant_a [N];
  logic [PR_W-1:0]     cdb_a   [N];
  logic [AR_W-1:0]     rdest_a [N];
  logic [PR_W-1:0]     rnew_a  [N];
  logic [PR_W-1:0]     rold_a  [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_unpack
      assign dest_a[g]  = disp_dest[g*AR_W +: AR_W];
      assign src1_a[g]  = disp_src1[g*AR_W +: AR_W];
      assign src2_a[g]  = disp_src2[g*AR_W +: AR_W];
      assign grant_a[g] = granted_regs[g*PR_COUNT +: PR_COUNT];
      assign cdb_a[g]   = cdb_tag[g*PR_W +: PR_W];
      assign rdest_a[g] = ret_dest[g*AR_W +: AR_W];
      assign rnew_a[g]  = ret_new_tag[g*PR_W +: PR_W];
      assign rold_a[g]  = ret_old_tag[g*PR_W +: PR_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PR_W-1:0]     spec_map_q [ARCH_REG_SZ];
  logic [PR_W-1:0]     spec_map_d [ARCH_REG_SZ];
  logic [PR_W-1:0]     arch_map_q [ARCH_REG_SZ];
  logic [PR_W-1:0]     arch_map_d [ARCH_REG_SZ];
  logic [PR_COUNT-1:0] ready_q;
  logic [PR_COUNT-1:0] ready_d;
  logic [PR_COUNT-1:0] free_mask_q;
  logic [PR_COUNT-1:0] free_mask_d;

  // --------------------------------------------------------------------------
  // Grant decode. Grants are one-hot, so OR-ing the indices of set bits
  // yields the index of the single set bit without a priority chain.
  // --------------------------------------------------------------------------
  logic [PR_W-1:0] grant_tag [N];
  logic [N-1:0]    has_grant;

  always_comb begin : grant_decode
    has_grant = '0;
    for (int i = 0; i < N; i++) begin
      grant_tag[i] = '0;
      has_grant[i] = |grant_a[i];
      for (int p = 0; p < PR_COUNT; p++) begin
        if (grant_a[i][p]) begin
          grant_tag[i] = grant_tag[i] | PR_W'(p);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Acceptance. Lanes are accepted in order; the first lane that asked for a
  // register and got none stops itself and every younger lane, so the group
  // never renames out of program order. Lanes without a destination do not
  // break the chain.
  // --------------------------------------------------------------------------
  logic [N-1:0]    alloc_req_w;
  logic [N-1:0]    rename_ok_w;
  logic [N-1:0]    writes_w;      // renamed lane that allocates a new PR
  logic [PR_W-1:0] new_tag_a [N];

  always_comb begin : accept
    logic chain;
    chain       = 1'b1;
    alloc_req_w = '0;
    rename_ok_w = '0;
    writes_w    = '0;
    for (int i = 0; i < N; i++) begin
      alloc_req_w[i] = disp_valid[i] & (dest_a[i] != '0) & ~recover;
      if (alloc_req_w[i] & ~has_grant[i]) begin
        chain = 1'b0;
      end
      rename_ok_w[i] = disp_valid[i] & ~recover & chain;
      writes_w[i]    = rename_ok_w[i] & (dest_a[i] != '0);
      new_tag_a[i]   = writes_w[i] ? grant_tag[i] : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Source and old-destination lookup. Start from the speculative map, then
  // let each older renamed lane writing the same arch reg override it; the
  // ascending loop leaves the youngest such lane in place. A bypassed tag was
  // just allocated, so it is never ready. A CDB hit this cycle makes a mapped
  // tag ready without waiting for the ready bit to be written.
  // --------------------------------------------------------------------------
  logic [PR_W-1:0] s1_tag [N];
  logic [PR_W-1:0] s2_tag [N];
  logic [PR_W-1:0] od_tag [N];
  logic [N-1:0]    s1_rdy;
  logic [N-1:0]    s2_rdy;

  always_comb begin : src_lookup
    s1_rdy = '0;
    s2_rdy = '0;
    for (int i = 0; i < N; i++) begin
      s1_tag[i] = spec_map_q[src1_a[i]];
      s2_tag[i] = spec_map_q[src2_a[i]];
      od_tag[i] = spec_map_q[dest_a[i]];
      s1_rdy[i] = ready_q[s1_tag[i]];
      s2_rdy[i] = ready_q[s2_tag[i]];
      for (int k = 0; k < N; k++) begin
        if (cdb_valid[k] && (cdb_a[k] == s1_tag[i])) s1_rdy[i] = 1'b1;
        if (cdb_valid[k] && (cdb_a[k] == s2_tag[i])) s2_rdy[i] = 1'b1;
      end
      for (int j = 0; j < i; j++) begin
        if (writes_w[j] && (dest_a[j] == src1_a[i])) begin
          s1_tag[i] = new_tag_a[j];
          s1_rdy[i] = 1'b0;
        end
        if (writes_w[j] && (dest_a[j] == src2_a[i])) begin
          s2_tag[i] = new_tag_a[j];
          s2_rdy[i] = 1'b0;
        end
        if (writes_w[j] && (dest_a[j] == dest_a[i])) begin
          od_tag[i] = new_tag_a[j];
        end
      end
      // Arch reg 0 is hard-wired to PR 0 and always available.
      if (src1_a[i] == '0) begin
        s1_tag[i] = '0;
        s1_rdy[i] = 1'b1;
      end
      if (src2_a[i] == '0) begin
        s2_tag[i] = '0;
        s2_rdy[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  always_comb begin : next_state
    // Retirement map: ascending lane order lets the youngest retire win.
    arch_map_d = arch_map_q;
    for (int i = 0; i < N; i++) begin
      if (ret_valid[i] && (rdest_a[i] != '0)) begin
        arch_map_d[rdest_a[i]] = rnew_a[i];
      end
    end

    // Speculative map: youngest renamed lane wins. On recover it snaps to
    // the retirement map including this cycle's retirements.
    spec_map_d = spec_map_q;
    for (int i = 0; i < N; i++) begin
      if (writes_w[i]) begin
        spec_map_d[dest_a[i]] = grant_tag[i];
      end
    end
    if (recover) begin
      spec_map_d = arch_map_d;
    end

    // Ready bits: CDB sets first so that an allocation of the same PR in the
    // same cycle clears it. Recover marks every committed mapping ready.
    ready_d = ready_q;
    for (int i = 0; i < N; i++) begin
      if (cdb_valid[i]) ready_d[cdb_a[i]] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (writes_w[i]) ready_d[grant_tag[i]] = 1'b0;
    end
    if (recover) begin
      for (int a = 0; a < ARCH_REG_SZ; a++) begin
        ready_d[arch_map_d[a]] = 1'b1;
      end
    end

    // Released PRs: old mappings of retiring writers, plus any grant that
    // was not consumed by a renamed lane, so no PR leaks from the freelist.
    free_mask_d = '0;
    for (int i = 0; i < N; i++) begin
      if (ret_valid[i] && (rdest_a[i] != '0)) begin
        free_mask_d[rold_a[i]] = 1'b1;
      end
      if (!writes_w[i]) begin
        free_mask_d = free_mask_d | grant_a[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers. Reset dominates every other update.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int a = 0; a < ARCH_REG_SZ; a++) begin
        spec_map_q[a] <= PR_W'(a);
        arch_map_q[a] <= PR_W'(a);
      end
      ready_q     <= '1;
      free_mask_q <= '0;
    end else begin
      spec_map_q  <= spec_map_d;
      arch_map_q  <= arch_map_d;
      ready_q     <= ready_d;
      free_mask_q <= free_mask_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output packing
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < N; g++) begin : g_pack
      assign src1_tag[g*PR_W +: PR_W] = s1_tag[g];
      assign src2_tag[g*PR_W +: PR_W] = s2_tag[g];
      assign new_tag[g*PR_W +: PR_W]  = new_tag_a[g];
      assign old_tag[g*PR_W +: PR_W]  = od_tag[g];
    end
  endgenerate

  assign alloc_req  = alloc_req_w;
  assign rename_ok  = rename_ok_w;
  assign src1_ready = s1_rdy;
  assign src2_ready = s2_rdy;
  assign free_mask  = free_mask_q;

endmodule
`default_nettype wire
